// File: rtl/memresp_pkg.sv
// Shared definitions for the memresp data-memory responder: FSM encodings and counter width.
package memresp_pkg;

    localparam int MEMRESP_WCNT_W = 4;
    localparam int MEMRESP_DATA_W = 24;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_ACCESS = 2'd3;

endpackage

// File: rtl/memresp_array.sv
// Single-port synchronous word RAM with registered, read-first output. Contents are never reset.
module memresp_array #(
    parameter int DEPTH_LOG2 = 12,
    parameter int WIDTH      = 24
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem_q[addr];
            if (we) begin
                mem_q[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/memresp.sv
// Data-memory responder: one outstanding request, WAIT_STATES extra cycles before the RAM access.
// Optional address range checking is enabled by defining MEMRESP_BOUNDS_EN.
module memresp
    import memresp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [23:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [MEMRESP_WCNT_W-1:0] WCNT_LOAD = MEMRESP_WCNT_W'(WAIT_STATES);

    logic [1:0]                state_q, state_d;
    logic [MEMRESP_WCNT_W-1:0] wcnt_q, wcnt_d;
    logic                      we_q;
    logic [DEPTH_LOG2-1:0]     idx_q;
    logic [23:0]               wdata_q;
    logic                      rd_ok_q;
    logic                      accept;
    logic                      access;
    logic                      hit_oob;
    logic                      ram_en;
    logic [23:0]               ram_rdata;
    logic                      unused_addr_hi;

    assign accept    = (state_q == ST_IDLE) && req_valid;
    assign access    = (state_q == ST_ACCESS);
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wcnt_d  = WCNT_LOAD;
                    state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end
                if (wcnt_q <= MEMRESP_WCNT_W'(1)) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                rd_ok_q <= 1'b0;
            end
            if (access) begin
                rd_ok_q <= !we_q && !hit_oob;
            end
        end
    end

    // Request latches only load on accept, so later input activity cannot disturb them.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[DEPTH_LOG2-1:0];
            wdata_q <= req_wdata;
        end
    end

`ifdef MEMRESP_BOUNDS_EN
    logic oob_q;
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                oob_q <= (req_addr >> DEPTH_LOG2) != 24'h0;
                err_q <= 1'b0;
            end
            if (access) begin
                err_q <= oob_q;
            end
        end
    end

    assign hit_oob = oob_q;
    assign rsp_err = err_q;
`else
    assign hit_oob = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign unused_addr_hi = ^(req_addr >> DEPTH_LOG2);

    // Gating with rst keeps an abandoned write from landing on the reset edge.
    assign ram_en = access && !rst && !hit_oob;

    memresp_array #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (MEMRESP_DATA_W)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (we_q),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign rsp_rdata = rd_ok_q ? ram_rdata : 24'h0;

endmodule

// File: tb/tb_memresp.sv
// Directed bench for memresp: index 0 instance has WAIT_STATES=0, index 1 has WAIT_STATES=2.
module tb_memresp;

    logic        clk;
    logic        rst;
    logic        req_valid_s [2];
    logic        req_ready_s [2];
    logic        req_we_s    [2];
    logic [23:0] req_addr_s  [2];
    logic [23:0] req_wdata_s [2];
    logic        rsp_valid_s [2];
    logic        rsp_ready_s [2];
    logic [23:0] rsp_rdata_s [2];
    logic        rsp_err_s   [2];
    logic        busy_s      [2];

    int errors = 0;
    int checks = 0;

`ifdef MEMRESP_BOUNDS_EN
    localparam logic        EXP_OOB_ERR = 1'b1;
    localparam logic [23:0] EXP_ALIAS   = 24'h0A0A0A;
`else
    localparam logic        EXP_OOB_ERR = 1'b0;
    localparam logic [23:0] EXP_ALIAS   = 24'h555555;
`endif

    memresp #(.DEPTH_LOG2(12), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_we(req_we_s[0]),
        .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
        .rsp_rdata(rsp_rdata_s[0]), .rsp_err(rsp_err_s[0]), .busy(busy_s[0])
    );

    memresp #(.DEPTH_LOG2(12), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_we(req_we_s[1]),
        .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
        .rsp_rdata(rsp_rdata_s[1]), .rsp_err(rsp_err_s[1]), .busy(busy_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for its accept edge, then count edges until rsp_valid is seen.
    task automatic issue(input int d, input logic we, input logic [23:0] addr,
                         input logic [23:0] wdata, output int lat);
        @(negedge clk);
        chk($sformatf("d%0d_ready_idle", d), 32'(req_ready_s[d]), 32'd1);
        req_valid_s[d] = 1'b1;
        req_we_s[d]    = we;
        req_addr_s[d]  = addr;
        req_wdata_s[d] = wdata;
        @(posedge clk);
        #1;
        req_valid_s[d] = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid_s[d] === 1'b1 || lat > 30) break;
            lat++;
        end
        $display("d%0d req we=%0d addr=%06h wdata=%06h latency=%0d", d, we, addr, wdata, lat);
    endtask

    // Called at a negedge while rsp_valid is high: capture, then complete the handshake.
    task automatic finish(input int d, output logic [23:0] rd, output logic err);
        rd  = rsp_rdata_s[d];
        err = rsp_err_s[d];
        chk($sformatf("d%0d_ready_in_resp", d), 32'(req_ready_s[d]), 32'd0);
        rsp_ready_s[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_s[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("d%0d_valid_after_hs", d), 32'(rsp_valid_s[d]), 32'd0);
        chk($sformatf("d%0d_ready_after_hs", d), 32'(req_ready_s[d]), 32'd1);
        $display("d%0d rsp rdata=%06h err=%0d", d, rd, err);
    endtask

    task automatic xfer(input int d, input logic we, input logic [23:0] addr,
                        input logic [23:0] wdata, input int exp_lat,
                        input logic [23:0] exp_rd, input logic exp_err, input string tag);
        int          lat;
        logic [23:0] rd;
        logic        err;
        issue(d, we, addr, wdata, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        finish(d, rd, err);
        chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int          lat;
        logic [23:0] rd;
        logic        err;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid_s[i] = 1'b0;
            req_we_s[i]    = 1'b0;
            req_addr_s[i]  = 24'h0;
            req_wdata_s[i] = 24'h0;
            rsp_ready_s[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_rst_ready", i), 32'(req_ready_s[i]), 32'd1);
            chk($sformatf("d%0d_rst_valid", i), 32'(rsp_valid_s[i]), 32'd0);
            chk($sformatf("d%0d_rst_busy", i), 32'(busy_s[i]), 32'd0);
            chk($sformatf("d%0d_rst_rdata", i), 32'(rsp_rdata_s[i]), 32'd0);
            chk($sformatf("d%0d_rst_err", i), 32'(rsp_err_s[i]), 32'd0);
        end

        // Two wait states: write then read back, latency 3.
        xfer(1, 1'b1, 24'h000010, 24'hABCDEF, 3, 24'h0, 1'b0, "ws2_write");

        // Stall the read response for 5 cycles while hammering the request inputs.
        issue(1, 1'b0, 24'h000010, 24'h0, lat);
        chk("ws2_read_lat", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 32'(rsp_valid_s[1]), 32'd1);
            chk("stall_rdata", 32'(rsp_rdata_s[1]), 32'hABCDEF);
            chk("stall_ready", 32'(req_ready_s[1]), 32'd0);
            req_valid_s[1] = 1'b1;
            req_we_s[1]    = 1'b1;
            req_addr_s[1]  = 24'h000010 + 24'(c);
            req_wdata_s[1] = 24'h000BAD;
            @(negedge clk);
        end
        req_valid_s[1] = 1'b0;
        finish(1, rd, err);
        chk("stall_final_rdata", 32'(rd), 32'hABCDEF);
        xfer(1, 1'b0, 24'h000010, 24'h0, 3, 24'hABCDEF, 1'b0, "stall_reread");

        // Zero wait states: one-cycle latency.
        xfer(0, 1'b1, 24'h000001, 24'h111111, 1, 24'h0, 1'b0, "ws0_wr1");
        xfer(0, 1'b1, 24'h000002, 24'h222222, 1, 24'h0, 1'b0, "ws0_wr2");
        xfer(0, 1'b0, 24'h000001, 24'h0, 1, 24'h111111, 1'b0, "ws0_rd1");
        xfer(0, 1'b0, 24'h000002, 24'h0, 1, 24'h222222, 1'b0, "ws0_rd2");

        // Reset during WAIT abandons the second write.
        xfer(1, 1'b1, 24'h000020, 24'h123456, 3, 24'h0, 1'b0, "rst_wr1");
        @(negedge clk);
        req_valid_s[1] = 1'b1;
        req_we_s[1]    = 1'b1;
        req_addr_s[1]  = 24'h000020;
        req_wdata_s[1] = 24'h777777;
        @(posedge clk);
        #1;
        req_valid_s[1] = 1'b0;
        @(negedge clk);
        chk("rst_busy_in_wait", 32'(busy_s[1]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy_after", 32'(busy_s[1]), 32'd0);
        chk("rst_ready_after", 32'(req_ready_s[1]), 32'd1);
        chk("rst_valid_after", 32'(rsp_valid_s[1]), 32'd0);
        repeat (4) @(negedge clk);
        $display("d1 reset during WAIT applied");
        xfer(1, 1'b0, 24'h000020, 24'h0, 3, 24'h123456, 1'b0, "rst_reread");

        // Out-of-range address: error response with bounds checking, alias otherwise.
        xfer(1, 1'b1, 24'h000000, 24'h0A0A0A, 3, 24'h0, 1'b0, "oob_wr0");
        xfer(1, 1'b1, 24'h001000, 24'h555555, 3, 24'h0, EXP_OOB_ERR, "oob_wr1000");
        xfer(1, 1'b0, 24'h000000, 24'h0, 3, EXP_ALIAS, 1'b0, "oob_rd0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
